// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life grid loader and simulation core:
// grid size defaults, frame length derivation and the loader state encoding.
package gol_pkg;

   localparam int unsigned CELLS_X_DEF = 32;
   localparam int unsigned CELLS_Y_DEF = CELLS_X_DEF / 16 * 9;

   // One bit per cell, packed eight cells per byte.
   function automatic int unsigned bytes_per_frame(input int unsigned cx,
                                                   input int unsigned cy);
      return cy * cx / 8;
   endfunction

   typedef enum logic [1:0] {
      LdIdle,
      LdLoad,
      LdCommit
   } loader_state_e;

endpackage

// File: rtl/gol_shadow_buf.sv
// Byte-addressed shadow copy of the cell grid; the whole grid is readable in parallel.
module gol_shadow_buf
   import gol_pkg::*;
#(
   parameter int unsigned CELLS_X = CELLS_X_DEF,
   parameter int unsigned CELLS_Y = CELLS_Y_DEF,
   parameter int unsigned AW      = 7
) (
   input  logic                            clk,
   input  logic                            we,
   input  logic [AW-1:0]                   addr,
   input  logic [7:0]                      wdata,
   output logic [CELLS_Y-1:0][CELLS_X-1:0] rdata
);

   localparam int unsigned BPF = bytes_per_frame(CELLS_X, CELLS_Y);

   // Byte k lands on flat bits 8k+7..8k, which is exactly row-major, LSB-first.
   logic [BPF-1:0][7:0] mem;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem;

endmodule

// File: rtl/grid_loader.sv
// Streams a bit-packed pattern frame into a shadow buffer and commits it to grid atomically.
// Optional GRID_LOADER_CHECKSUM_EN appends an XOR checksum byte that gates the commit.
module grid_loader
   import gol_pkg::*;
#(
   parameter int unsigned CELLS_X = CELLS_X_DEF,
   parameter int unsigned CELLS_Y = CELLS_Y_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [7:0]                      s_data,
   input  logic                            s_sof,
   output logic [CELLS_Y-1:0][CELLS_X-1:0] grid,
   output logic                            overwrite,
   output logic                            busy,
   output logic                            err
);

   localparam int unsigned BPF = bytes_per_frame(CELLS_X, CELLS_Y);
   localparam int unsigned KW  = $clog2(BPF + 2);
   localparam int unsigned AW  = (BPF > 1) ? $clog2(BPF) : 1;
`ifdef GRID_LOADER_CHECKSUM_EN
   localparam int unsigned NBYTES = BPF + 1;
`else
   localparam int unsigned NBYTES = BPF;
`endif
   localparam logic [KW-1:0] LAST = KW'(NBYTES - 1);

   loader_state_e                   state;
   logic [KW-1:0]                   k;
   logic                            accept;
   logic                            wr_en;
   logic [AW-1:0]                   wr_addr;
   logic [CELLS_Y-1:0][CELLS_X-1:0] shadow;
`ifdef GRID_LOADER_CHECKSUM_EN
   logic [7:0]                      csum;
`endif

   assign s_ready = (state != LdCommit);
   assign busy    = (state != LdIdle);
   assign accept  = s_valid && s_ready;

   // The checksum byte (index BPF) never reaches the shadow.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      if (!rst && accept && s_sof) begin
         wr_en = 1'b1;
      end else if (!rst && accept && state == LdLoad && k < KW'(BPF)) begin
         wr_en   = 1'b1;
         wr_addr = AW'(k);
      end
   end

   gol_shadow_buf #(
      .CELLS_X (CELLS_X),
      .CELLS_Y (CELLS_Y),
      .AW      (AW)
   ) u_shadow (
      .clk   (clk),
      .we    (wr_en),
      .addr  (wr_addr),
      .wdata (s_data),
      .rdata (shadow)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LdIdle;
         k         <= '0;
         grid      <= '0;
         overwrite <= 1'b0;
         err       <= 1'b0;
`ifdef GRID_LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         overwrite <= 1'b0;
         err       <= 1'b0;
         case (state)
            LdIdle: begin
               if (accept && s_sof) begin
                  k     <= KW'(1);
                  state <= (LAST == '0) ? LdCommit : LdLoad;
`ifdef GRID_LOADER_CHECKSUM_EN
                  csum  <= s_data;
`endif
               end
            end
            LdLoad: begin
               if (accept) begin
                  if (s_sof) begin
                     k    <= KW'(1);
                     err  <= 1'b1;
`ifdef GRID_LOADER_CHECKSUM_EN
                     csum <= s_data;
`endif
                  end else if (k == LAST) begin
                     k <= '0;
`ifdef GRID_LOADER_CHECKSUM_EN
                     if (s_data == csum) begin
                        state <= LdCommit;
                     end else begin
                        err   <= 1'b1;
                        state <= LdIdle;
                     end
`else
                     state <= LdCommit;
`endif
                  end else begin
                     k <= k + KW'(1);
`ifdef GRID_LOADER_CHECKSUM_EN
                     csum <= csum ^ s_data;
`endif
                  end
               end
            end
            LdCommit: begin
               grid      <= shadow;
               overwrite <= 1'b1;
               k         <= '0;
               state     <= LdIdle;
            end
            default: state <= LdIdle;
         endcase
      end
   end

endmodule

// File: doc/grid_loader.md
GRID_LOADER -- requirements
Module: grid_loader

Interface
REQ-001 The block SHALL have parameter CELLS_X, default 32, meaning grid width in cells; it must be a multiple of 8.
REQ-002 The block SHALL have parameter CELLS_Y, default 18 (CELLS_X/16*9), meaning grid height in cells.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port s_valid, input, 1 bit: byte offered.
REQ-006 The block SHALL have port s_ready, output, 1 bit: byte accepted when s_valid && s_ready at posedge.
REQ-007 The block SHALL have port s_data, input, 8 bits: pattern byte.
REQ-008 The block SHALL have port s_sof, input, 1 bit: qualifies s_data as first byte of a frame.
REQ-009 The block SHALL have port grid, output, CELLS_Y x CELLS_X bits: committed pattern; it drives cells_in of the simulation core.
REQ-010 The block SHALL have port overwrite, output, 1 bit: one-cycle commit pulse; it drives overwrite of the simulation core.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in LOAD or COMMIT.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse on aborted or rejected frame.

Function
REQ-013 The frame SHALL be BPF = CELLS_Y*CELLS_X/8 data bytes (72 at defaults), row 0 first, CELLS_X/8 bytes per row.
REQ-014 Byte index k SHALL map to row k/(CELLS_X/8), with bit b of byte (k mod CELLS_X/8) mapping to column 8*(k mod CELLS_X/8)+b (LSB = lowest column).
REQ-015 The FSM SHALL have states IDLE, LOAD and COMMIT.
REQ-016 In IDLE, s_ready=1; accepted bytes without s_sof SHALL be discarded; an accepted byte with s_sof SHALL be stored as k=0, followed by a transition to LOAD (or to COMMIT when BPF==1).
REQ-017 In LOAD, s_ready=1; each accepted byte SHALL be written to the shadow buffer at index k, and k SHALL increment.
REQ-018 Acceptance of the final byte in LOAD SHALL move the FSM to COMMIT.
REQ-019 An s_sof byte accepted in LOAD SHALL restart the frame: the byte is stored as k=0, the FSM stays in LOAD, err pulses the next cycle, and the old shadow contents are abandoned.
REQ-020 In COMMIT, s_ready=0 and grid SHALL load the shadow buffer at the COMMIT edge.
REQ-021 overwrite SHALL be high for exactly the one cycle after that edge, so grid is already stable when overwrite rises.
REQ-022 After COMMIT, the FSM SHALL return to IDLE.
REQ-023 Latency SHALL be one cycle of overwrite high, starting two edges after acceptance of the last byte.
REQ-024 grid SHALL change only at commit; partial frames SHALL never appear on grid.
REQ-025 s_valid low mid-frame SHALL stall without timeout; k SHALL hold.
REQ-026 The byte counter SHALL be ceil(log2(BPF+2)) bits and SHALL never wrap within a frame.

Reset
REQ-027 rst SHALL force state IDLE, k=0, grid all-zero, overwrite=0, err=0 and busy=0, with s_ready=1 from the first cycle after release.
REQ-028 rst asserted mid-frame SHALL discard the frame with no overwrite pulse, and rst SHALL take priority over any simultaneous byte acceptance.
REQ-029 The shadow buffer need not be reset.

Configuration
REQ-030 GRID_LOADER_CHECKSUM_EN defined: the frame SHALL be BPF+1 bytes, where the last byte is the XOR of all BPF data bytes.
REQ-031 GRID_LOADER_CHECKSUM_EN defined: on a match the FSM SHALL go to COMMIT; on a mismatch err SHALL pulse, the FSM SHALL return to IDLE, and grid SHALL be unchanged with no overwrite.
REQ-032 GRID_LOADER_CHECKSUM_EN undefined: the frame SHALL be BPF bytes, no checksum logic SHALL exist, and err SHALL pulse only for the s_sof restart.

Structure
REQ-033 A shared package gol_pkg SHALL hold CELLS_X/CELLS_Y defaults, the BPF derivation and the loader state enum, and SHALL be shared with the simulation core.
REQ-034 The block SHALL have one sub-module, gol_shadow_buf: byte-addressed write into the CELLS_Y x CELLS_X shadow, with a parallel read.

Verification
REQ-035 Reset, then 72 bytes of 0x00 except byte 4 = 0x01 (with s_sof on byte 0) SHALL result in grid[1][0]=1, all else 0, and overwrite high exactly one cycle, 2 edges after byte 71.
REQ-036 A frame with s_valid toggled 1/0 every cycle SHALL produce the same grid as the back-to-back case, with busy high throughout and s_ready=0 only in COMMIT.
REQ-037 30 bytes, then a new s_sof frame of 72 bytes of 0xFF, SHALL produce an err pulse after byte 30 and then grid all-ones with one overwrite.
REQ-038 5 bytes without s_sof in IDLE, then a valid frame, SHALL cause the first 5 bytes to be ignored and only the valid frame to be committed.
REQ-039 rst pulsed at byte 40, then no further frame, SHALL leave grid all-zero, with no overwrite and busy=0.
REQ-040 With GRID_LOADER_CHECKSUM_EN, a 72×0xA5 frame plus checksum 0x00 SHALL commit, and the same frame with checksum 0x01 SHALL produce err, no overwrite, and grid unchanged.
